// File: rtl/rf_arb_pkg.sv
// Shared types and sizing for the two-client register-file access controller.
//   DW        : data width of the register file buses
//   AW        : register address width
//   NREG      : number of registers (2**AW)
//   INIT_LAST : last register cleared by the start-up sweep
//   state_e   : controller phase (start-up clear sweep, then arbitration)
//   owner_e   : which client owns a transaction
package rf_arb_pkg;

  localparam int DW        = 8;
  localparam int AW        = 3;
  localparam int NREG      = 2 ** AW;
  localparam int INIT_LAST = NREG - 1;

  typedef enum logic {INIT, ARB} state_e;
  typedef enum logic {OWN_A, OWN_B} owner_e;

endpackage

// File: rtl/rf_arbiter_if.sv
// One client's request/response bundle towards the register-file controller.
//   req    : request, held by the client until gnt
//   we     : write wdata to rw as part of this transaction
//   rw     : write address
//   wdata  : write data
//   rx, ry : read addresses for the X and Y ports
//   gnt    : granted this cycle (combinational from the controller)
//   rvalid : one-cycle pulse, read data valid on the shared rdata_x/rdata_y
// master = client side, slave = controller side.
interface rf_client_if;
  import rf_arb_pkg::*;

  logic          req;
  logic          we;
  logic [AW-1:0] rw;
  logic [DW-1:0] wdata;
  logic [AW-1:0] rx;
  logic [AW-1:0] ry;
  logic          gnt;
  logic          rvalid;

  modport master (output req, we, rw, wdata, rx, ry, input gnt, rvalid);
  modport slave  (input req, we, rw, wdata, rx, ry, output gnt, rvalid);
endinterface

// File: rtl/rf_arbiter_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_a, req_b : requests
//   en           : arbitration enable; no grant while low
//   gnt_a, gnt_b : combinational one-hot (or zero) grant
// On contention the client that was not granted last wins; the history flop
// resets to B so that A wins the first contention.
module rr_arb2
  import rf_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic en,
  output logic gnt_a,
  output logic gnt_b
);

  owner_e r_last;

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (en) begin
      if (req_a && req_b) begin
        gnt_a = (r_last == OWN_B);
        gnt_b = (r_last == OWN_A);
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: flops use non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    if (!rst_n)     r_last <= OWN_B;
    else if (gnt_a) r_last <= OWN_A;
    else if (gnt_b) r_last <= OWN_B;
  end

endmodule

// File: rtl/rf_arbiter.sv
// Two-client access controller for an 8x8 register file (reg0 reads zero,
// combinational reads, write on the clock edge).
//   Clk, Rst_n       : clock, asynchronous active-low reset
//   a_if, b_if       : client request/grant/rvalid bundles
//   rdata_x, rdata_y : registered read results for the owner of rvalid
//   init_done        : high once registers 1..NREG-1 have been cleared
//   rf_wen, rf_rw, rf_busw, rf_rx, rf_ry : registered drive to the register file
//   rf_busx, rf_busy : combinational read data from the register file
// A grant in cycle N registers the request onto the rf_* outputs, the file
// answers during N+1 (its write commits at the end of N+1), and the answer is
// captured into rdata_x/rdata_y with a one-cycle rvalid in N+2.
module rf_arbiter
  import rf_arb_pkg::*;
(
  input  logic          Clk,
  input  logic          Rst_n,
  rf_client_if.slave    a_if,
  rf_client_if.slave    b_if,
  output logic [DW-1:0] rdata_x,
  output logic [DW-1:0] rdata_y,
  output logic          init_done,
  output logic          rf_wen,
  output logic [AW-1:0] rf_rw,
  output logic [DW-1:0] rf_busw,
  output logic [AW-1:0] rf_rx,
  output logic [AW-1:0] rf_ry,
  input  logic [DW-1:0] rf_busx,
  input  logic [DW-1:0] rf_busy
);

  state_e        r_state, w_next_state;
  logic [AW-1:0] r_cnt, w_next_cnt;
  logic          w_arb_en, w_gnt_a, w_gnt_b;

  logic          w_sel_we;
  logic [AW-1:0] w_sel_rw, w_sel_rx, w_sel_ry;
  logic [DW-1:0] w_sel_wdata;

  logic          r_wen;
  logic [AW-1:0] r_rw, r_rx, r_ry;
  logic [DW-1:0] r_busw;
  logic          r_pend_vld;
  owner_e        r_pend_own;
  logic          r_a_rvalid, r_b_rvalid;
  logic [DW-1:0] r_rdata_x, r_rdata_y;

  rr_arb2 u_rr_arb2 (
    .clk   (Clk),
    .rst_n (Rst_n),
    .req_a (a_if.req),
    .req_b (b_if.req),
    .en    (w_arb_en),
    .gnt_a (w_gnt_a),
    .gnt_b (w_gnt_b)
  );

  // Fields of whichever client is granted; only meaningful when a grant exists.
  assign w_sel_we    = w_gnt_b ? b_if.we    : a_if.we;
  assign w_sel_rw    = w_gnt_b ? b_if.rw    : a_if.rw;
  assign w_sel_wdata = w_gnt_b ? b_if.wdata : a_if.wdata;
  assign w_sel_rx    = w_gnt_b ? b_if.rx    : a_if.rx;
  assign w_sel_ry    = w_gnt_b ? b_if.ry    : a_if.ry;

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_arb_en     = 1'b0;
    case (r_state)
      INIT: begin
        w_next_cnt = r_cnt + 1'b1;
        if (r_cnt == AW'(INIT_LAST)) w_next_state = ARB;
      end
      ARB: w_arb_en = 1'b1;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= INIT;
      r_cnt   <= AW'(1);
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_wen      <= 1'b0;
      r_rw       <= '0;
      r_busw     <= '0;
      r_rx       <= '0;
      r_ry       <= '0;
      r_pend_vld <= 1'b0;
      r_pend_own <= OWN_A;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_rdata_x  <= '0;
      r_rdata_y  <= '0;
    end else begin
      if (r_state == INIT) begin
        // Clear sweep: one register per cycle, reads parked on reg0.
        r_wen  <= 1'b1;
        r_rw   <= r_cnt;
        r_busw <= '0;
        r_rx   <= '0;
        r_ry   <= '0;
      end else if (w_gnt_a || w_gnt_b) begin
        r_wen  <= w_sel_we;
        r_rw   <= w_sel_rw;
        r_busw <= w_sel_wdata;
        r_rx   <= w_sel_rx;
        r_ry   <= w_sel_ry;
      end else begin
        // Idle: address/data hold, only the write strobe drops.
        r_wen  <= 1'b0;
      end

      r_pend_vld <= w_gnt_a || w_gnt_b;
      r_pend_own <= w_gnt_b ? OWN_B : OWN_A;

      // The file's combinational answer is valid the cycle after the grant.
      r_a_rvalid <= r_pend_vld && (r_pend_own == OWN_A);
      r_b_rvalid <= r_pend_vld && (r_pend_own == OWN_B);
      if (r_pend_vld) begin
        r_rdata_x <= rf_busx;
        r_rdata_y <= rf_busy;
      end
    end
  end

  assign a_if.gnt    = w_gnt_a;
  assign b_if.gnt    = w_gnt_b;
  assign a_if.rvalid = r_a_rvalid;
  assign b_if.rvalid = r_b_rvalid;
  assign rdata_x     = r_rdata_x;
  assign rdata_y     = r_rdata_y;
  assign init_done   = (r_state == ARB);
  assign rf_wen      = r_wen;
  assign rf_rw       = r_rw;
  assign rf_busw     = r_busw;
  assign rf_rx       = r_rx;
  assign rf_ry       = r_ry;

endmodule

// File: tb/tb_rf_arbiter.sv
// Bench for rf_arbiter: a behavioural register file hangs off the rf_* ports,
// two client drivers issue directed and random transactions, and a monitor
// keeps an abstract model (register array + last winner) to predict grants
// and read data; expected responses queue up at grant time and are popped
// when the DUT raises rvalid.
module tb_rf_arbiter;
  import rf_arb_pkg::*;

  localparam int GNT_BUDGET = 40;
  localparam int RV_BUDGET  = 8;

  typedef struct {
    bit            own_b;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    int            cyc;
  } exp_t;

  logic          Clk   = 1'b0;
  logic          Rst_n = 1'b1;
  logic [DW-1:0] rdata_x, rdata_y, rf_busw, rf_busx, rf_busy;
  logic [AW-1:0] rf_rw, rf_rx, rf_ry;
  logic          init_done, rf_wen;

  rf_client_if a_if ();
  rf_client_if b_if ();

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int since_rst = 0;

  always #5 Clk = ~Clk;

  rf_arbiter dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .a_if      (a_if),
    .b_if      (b_if),
    .rdata_x   (rdata_x),
    .rdata_y   (rdata_y),
    .init_done (init_done),
    .rf_wen    (rf_wen),
    .rf_rw     (rf_rw),
    .rf_busw   (rf_busw),
    .rf_rx     (rf_rx),
    .rf_ry     (rf_ry),
    .rf_busx   (rf_busx),
    .rf_busy   (rf_busy)
  );

  // Register file: not reset; contents are scrambled while Rst_n is low so the
  // clear sweep has something to clear.
  logic [DW-1:0] rf_mem [NREG];
  always @(posedge Clk) begin
    if (!Rst_n) begin
      for (int i = 1; i < NREG; i++) rf_mem[i] <= DW'($urandom);
    end else if (rf_wen && rf_rw != '0) begin
      rf_mem[rf_rw] <= rf_busw;
    end
  end
  assign rf_busx = (rf_rx == '0) ? '0 : rf_mem[rf_rx];
  assign rf_busy = (rf_ry == '0) ? '0 : rf_mem[rf_ry];

  always @(posedge Clk) cyc <= cyc + 1;

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)              since_rst <= 0;
    else if (since_rst < 1000) since_rst <= since_rst + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [DW-1:0] model [NREG];
  exp_t          sb [$];
  bit            last_b   = 1'b1;
  bit            exp_wen  = 1'b0;
  logic [DW-1:0] hold_x   = '0;
  logic [DW-1:0] hold_y   = '0;

  always @(negedge Clk) begin : monitor
    exp_t          e;
    bit            ready, eg_a, eg_b, cl, we;
    logic [AW-1:0] rw, rx, ry;
    logic [DW-1:0] wd;
    if (!Rst_n) begin
      check("reset_outputs",
            64'({rf_wen, rf_rw, rf_busw, rf_rx, rf_ry, rdata_x, rdata_y,
                 a_if.rvalid, b_if.rvalid, a_if.gnt, b_if.gnt, init_done}), 64'd0);
      sb.delete();
      for (int i = 0; i < NREG; i++) model[i] = '0;
      last_b  = 1'b1;
      exp_wen = 1'b0;
      hold_x  = '0;
      hold_y  = '0;
    end else begin
      ready = (since_rst >= NREG - 1);

      // Clear sweep: the k-th cycle after release shows register k being written.
      if (since_rst >= 1 && since_rst <= NREG - 1) begin
        check("init_sweep", 64'({rf_wen, rf_rw, rf_busw, rf_rx, rf_ry}),
              64'({1'b1, AW'(since_rst), DW'(0), AW'(0), AW'(0)}));
      end
      check("init_done", 64'(init_done), 64'(ready));

      eg_a = 1'b0;
      eg_b = 1'b0;
      if (ready) begin
        if (a_if.req && b_if.req) begin
          eg_a = last_b;
          eg_b = !last_b;
        end else begin
          eg_a = a_if.req;
          eg_b = b_if.req;
        end
      end
      check("grant", 64'({a_if.gnt, b_if.gnt}), 64'({eg_a, eg_b}));

      if (since_rst >= NREG) check("rf_wen", 64'(rf_wen), 64'(exp_wen));
      exp_wen = 1'b0;

      if (a_if.rvalid || b_if.rvalid) begin
        if (sb.size() == 0) begin
          check("rvalid_expected", 64'({a_if.rvalid, b_if.rvalid}), 64'd0);
        end else begin
          e = sb.pop_front();
          check("rvalid_owner", 64'({a_if.rvalid, b_if.rvalid}), e.own_b ? 64'd1 : 64'd2);
          check("rdata_x", 64'(rdata_x), 64'(e.x));
          check("rdata_y", 64'(rdata_y), 64'(e.y));
          check("read_latency", 64'(cyc - e.cyc), 64'd2);
          hold_x = e.x;
          hold_y = e.y;
        end
      end else begin
        check("rdata_hold", 64'({rdata_x, rdata_y}), 64'({hold_x, hold_y}));
      end

      // Accept the granted transaction: reads see every earlier grant's write
      // but not this transaction's own write.
      if (a_if.gnt || b_if.gnt) begin
        cl = b_if.gnt;
        we = cl ? b_if.we    : a_if.we;
        rw = cl ? b_if.rw    : a_if.rw;
        wd = cl ? b_if.wdata : a_if.wdata;
        rx = cl ? b_if.rx    : a_if.rx;
        ry = cl ? b_if.ry    : a_if.ry;
        e.own_b = cl;
        e.x     = (rx == '0) ? '0 : model[rx];
        e.y     = (ry == '0) ? '0 : model[ry];
        e.cyc   = cyc;
        sb.push_back(e);
        if (we && rw != '0) model[rw] = wd;
        last_b  = cl;
        exp_wen = we;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Present a request, hold it until granted (bounded), then drop it.
  task automatic issue(input bit cl, input bit we, input logic [AW-1:0] rw,
                       input logic [DW-1:0] wd, input logic [AW-1:0] rx,
                       input logic [AW-1:0] ry);
    bit got = 1'b0;
    if (cl) begin
      b_if.req = 1'b1; b_if.we = we; b_if.rw = rw; b_if.wdata = wd; b_if.rx = rx; b_if.ry = ry;
    end else begin
      a_if.req = 1'b1; a_if.we = we; a_if.rw = rw; a_if.wdata = wd; a_if.rx = rx; a_if.ry = ry;
    end
    for (int i = 0; i < GNT_BUDGET && !got; i++) begin
      @(negedge Clk);
      got = cl ? b_if.gnt : a_if.gnt;
    end
    check(cl ? "b_gnt_in_budget" : "a_gnt_in_budget", 64'(got), 64'd1);
    @(posedge Clk);
    #1;
    if (cl) b_if.req = 1'b0;
    else    a_if.req = 1'b0;
  endtask

  task automatic wait_rv(input bit cl, output logic [DW-1:0] x, output logic [DW-1:0] y);
    bit got = 1'b0;
    x = '0;
    y = '0;
    for (int i = 0; i < RV_BUDGET && !got; i++) begin
      @(negedge Clk);
      got = cl ? b_if.rvalid : a_if.rvalid;
      if (got) begin
        x = rdata_x;
        y = rdata_y;
      end
    end
    check("rvalid_in_budget", 64'(got), 64'd1);
    @(posedge Clk);
    #1;
  endtask

  task automatic rand_client(input bit cl, input int n);
    for (int k = 0; k < n; k++) begin
      idle(int'($urandom_range(0, 2)));
      issue(cl, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
            AW'($urandom), AW'($urandom));
    end
  endtask

  initial begin
    logic [DW-1:0] x, y;
    a_if.req = 1'b0; a_if.we = 1'b0; a_if.rw = '0; a_if.wdata = '0; a_if.rx = '0; a_if.ry = '0;
    b_if.req = 1'b0; b_if.we = 1'b0; b_if.rw = '0; b_if.wdata = '0; b_if.rx = '0; b_if.ry = '0;
    #2 Rst_n = 1'b0;
    idle(3);

    // Request held through the clear sweep; write 0xAA to reg1.
    fork
      issue(1'b0, 1'b1, 3'd1, 8'hAA, 3'd1, 3'd0);
      begin
        idle(1);
        Rst_n = 1'b1;
      end
    join
    idle(3);
    issue(1'b0, 1'b0, 3'd0, 8'h00, 3'd1, 3'd0);
    wait_rv(1'b0, x, y);
    check("read_back_x", 64'(x), 64'hAA);
    check("read_back_y", 64'(y), 64'h00);

    // Continuous contention: B writes 0xFF to reg7 while A keeps reading reg7.
    fork
      begin
        issue(1'b1, 1'b1, 3'd7, 8'hFF, 3'd0, 3'd0);
        repeat (3) issue(1'b1, 1'b0, 3'd0, 8'h00, 3'd7, 3'd1);
      end
      repeat (4) issue(1'b0, 1'b0, 3'd0, 8'h00, 3'd7, 3'd1);
    join
    idle(3);

    // Write to reg0 is ignored by the file.
    issue(1'b0, 1'b1, 3'd0, 8'hCC, 3'd0, 3'd0);
    idle(3);
    issue(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
    wait_rv(1'b0, x, y);
    check("reg0_reads_zero", 64'(x), 64'h00);

    // Read of a register in the same transaction that writes it: old value.
    issue(1'b1, 1'b1, 3'd3, 8'h55, 3'd3, 3'd0);
    wait_rv(1'b1, x, y);
    check("same_txn_old_value", 64'(x), 64'h00);
    issue(1'b1, 1'b0, 3'd0, 8'h00, 3'd3, 3'd0);
    wait_rv(1'b1, x, y);
    check("next_txn_new_value", 64'(x), 64'h55);

    // Random traffic from both clients.
    fork
      rand_client(1'b0, 150);
      rand_client(1'b1, 150);
    join
    idle(4);

    // Reset one cycle after a grant: the pending rvalid must vanish and the
    // sweep must rerun; both clients then contend straight out of reset.
    issue(1'b0, 1'b0, 3'd0, 8'h00, 3'd5, 3'd6);
    Rst_n = 1'b0;
    idle(2);
    fork
      begin
        issue(1'b0, 1'b0, 3'd0, 8'h00, 3'd1, 3'd2);
        wait_rv(1'b0, x, y);
        check("post_reset_reg1", 64'(x), 64'h00);
        check("post_reset_reg2", 64'(y), 64'h00);
      end
      issue(1'b1, 1'b0, 3'd0, 8'h00, 3'd1, 3'd3);
      begin
        idle(1);
        Rst_n = 1'b1;
      end
    join
    idle(6);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
